// File: rtl/hazard3_decode_predict_pkg.sv
// Shared RV32 decode constants: opcodes, immediate formats and link-register test.
// Combinational helpers only; no state, no handshakes.
package hazard3_decode_predict_pkg;

  localparam logic [6:0] RV_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] RV_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] RV_OPC_BRANCH = 7'b1100011;

  function automatic logic is_jal(input logic [31:0] i);
    return i[6:0] == RV_OPC_JAL;
  endfunction

  function automatic logic is_jalr(input logic [31:0] i);
    return (i[6:0] == RV_OPC_JALR) && (i[14:12] == 3'b000);
  endfunction

  function automatic logic is_branch(input logic [31:0] i);
    return i[6:0] == RV_OPC_BRANCH;
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  // x1 (ra) and x5 (t0) are the ABI link registers
  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/hazard3_ras.sv
// Return-address stack as a circular buffer; push overwrites oldest when full.
// Zero-latency top/empty; updates take effect on the next edge, flush has priority.
module hazard3_ras #(
  parameter int DEPTH  = 2,
  parameter int W_ADDR = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [W_ADDR-1:0] push_data,
  input  logic              flush,
  output logic [W_ADDR-1:0] top,
  output logic              empty
);

  generate
    if (DEPTH == 0) begin : g_none
      assign top   = '0;
      assign empty = 1'b1;
    end else begin : g_stack
      localparam int W_PTR = (DEPTH > 1) ? $clog2(DEPTH) : 1;
      localparam int W_CNT = $clog2(DEPTH + 1);

      logic [W_ADDR-1:0] r_mem [DEPTH];
      logic [W_PTR-1:0]  r_wr_ptr;
      logic [W_CNT-1:0]  r_count;
      logic [W_PTR-1:0]  w_top_ptr;
      logic              w_empty;
      logic              w_full;

      assign w_top_ptr = r_wr_ptr - W_PTR'(1);
      assign w_empty   = (r_count == '0);
      assign w_full    = (r_count == W_CNT'(DEPTH));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_wr_ptr <= '0;
          r_count  <= '0;
          for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
        end else if (flush) begin
          r_count <= '0;
        end else if (push && pop && !w_empty) begin
          r_mem[w_top_ptr] <= push_data;
        end else if (push) begin
          r_mem[r_wr_ptr] <= push_data;
          r_wr_ptr        <= r_wr_ptr + W_PTR'(1);
          if (!w_full) r_count <= r_count + W_CNT'(1);
        end else if (pop && !w_empty) begin
          r_wr_ptr <= w_top_ptr;
          r_count  <= r_count - W_CNT'(1);
        end
      end

      assign top   = r_mem[w_top_ptr];
      assign empty = w_empty;
    end
  endgenerate

endmodule

// File: rtl/hazard3_decode_predict.sv
// Decode-stage PC and early-jump unit: JAL, BTFN branches and RAS-predicted returns.
// Jump request is combinational; fetch backpressure stalls D, a jump taken under stall locks the CIR.
module hazard3_decode_predict
  import hazard3_decode_predict_pkg::*;
#(
  parameter int                W_ADDR         = 32,
  parameter logic [W_ADDR-1:0] RESET_VECTOR   = '0,
  parameter bit                BRANCH_PREDICT = 1'b1,
  parameter int                RAS_DEPTH      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       d_instr,
  input  logic              d_instr_is_32bit,
  input  logic              d_instr_vld,
  input  logic              x_stall,
  input  logic              f_jump_rdy,
  input  logic              f_jump_now,
  input  logic [W_ADDR-1:0] f_jump_target,
  input  logic              m_flush,
  output logic              d_stall,
  output logic              df_cir_lock,
  output logic              d_jump_req,
  output logic [W_ADDR-1:0] d_jump_target,
  output logic [W_ADDR-1:0] d_pc,
  output logic [W_ADDR-1:0] d_mispredict_addr,
  output logic              d_pred_taken
);

  logic [W_ADDR-1:0] r_pc;
  logic              r_cir_lock_prev;

  logic [W_ADDR-1:0] w_pc_next, w_tgt_jal, w_tgt_br, w_ras_top;
  logic [31:0]       w_imm_b;
  logic [4:0]        w_rs1, w_rd;
  logic              w_is_jal, w_is_jalr, w_is_br, w_is_call, w_is_ret;
  logic              w_ras_empty, w_ras_hit, w_jump_en, w_pred, w_lock_assert;
  logic              w_ras_upd;

  assign w_pc_next = r_pc + (d_instr_is_32bit ? W_ADDR'(4) : W_ADDR'(2));
  assign w_imm_b   = imm_b(d_instr);
  assign w_tgt_jal = r_pc + W_ADDR'($signed(imm_j(d_instr)));
  assign w_tgt_br  = r_pc + W_ADDR'($signed(w_imm_b));

  assign w_is_jal  = is_jal(d_instr);
  assign w_is_jalr = is_jalr(d_instr);
  assign w_is_br   = is_branch(d_instr);
  assign w_rs1     = d_instr[19:15];
  assign w_rd      = d_instr[11:7];
  assign w_is_call = (w_is_jal || w_is_jalr) && is_link(w_rd);
  assign w_is_ret  = w_is_jalr && is_link(w_rs1) && (w_rs1 != w_rd);
  assign w_ras_hit = (RAS_DEPTH > 0) && w_is_ret && !w_ras_empty;
  assign w_jump_en = d_instr_vld && !r_cir_lock_prev && !m_flush;

  always_comb begin
    w_pred            = 1'b0;
    d_jump_target     = w_tgt_jal;
    d_mispredict_addr = w_pc_next;
    if (w_is_jal) begin
      w_pred = 1'b1;
    end else if (w_is_br) begin
      if (BRANCH_PREDICT && w_imm_b[31]) begin
        w_pred        = 1'b1;
        d_jump_target = w_tgt_br;
      end else begin
        d_mispredict_addr = w_tgt_br;
      end
    end else if (w_is_jalr) begin
      w_pred        = w_ras_hit;
      d_jump_target = w_ras_top & ~W_ADDR'(1);
    end
  end

  assign d_jump_req    = w_jump_en && w_pred;
  // A locked CIR always holds a jump already issued; the RAS may have popped since
  assign d_pred_taken  = w_pred || r_cir_lock_prev;
  assign d_stall       = x_stall || !d_instr_vld || (d_jump_req && !f_jump_rdy);
  assign w_lock_assert = d_jump_req && f_jump_rdy && d_stall;
  assign df_cir_lock   = (r_cir_lock_prev && d_stall) || w_lock_assert;
  assign d_pc          = r_pc;

  // One RAS update per instruction: at jump acceptance or when it leaves D unlocked
  assign w_ras_upd = (d_jump_req && f_jump_rdy) || (!d_stall && !r_cir_lock_prev && d_instr_vld);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc            <= RESET_VECTOR;
      r_cir_lock_prev <= 1'b0;
    end else begin
      r_cir_lock_prev <= df_cir_lock && !m_flush;
      if ((f_jump_now && !w_lock_assert) || (r_cir_lock_prev && !d_stall))
        r_pc <= f_jump_target;
      else if (!d_stall && !df_cir_lock)
        r_pc <= w_pc_next;
    end
  end

  hazard3_ras #(
    .DEPTH  (RAS_DEPTH),
    .W_ADDR (W_ADDR)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_ras_upd && w_is_call),
    .pop       (w_ras_upd && w_is_ret),
    .push_data (w_pc_next),
    .flush     (m_flush),
    .top       (w_ras_top),
    .empty     (w_ras_empty)
  );

endmodule

// File: tb/tb_hazard3_decode_predict.sv
// Scoreboard bench for hazard3_decode_predict: BTFN instance plus a not-taken instance on shared inputs.
// Each step pushes expectations while driving, then drains and compares them mid-cycle.
module tb_hazard3_decode_predict;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] d_instr = NOP;
  logic        d_instr_is_32bit = 1'b1;
  logic        d_instr_vld = 1'b0;
  logic        x_stall = 1'b0;
  logic        f_jump_rdy = 1'b0;
  logic        f_jump_now = 1'b0;
  logic [31:0] f_jump_target = '0;
  logic        m_flush = 1'b0;

  logic        d_stall, df_cir_lock, d_jump_req, d_pred_taken;
  logic [31:0] d_jump_target, d_pc, d_mispredict_addr;
  logic        d_stall0, df_cir_lock0, d_jump_req0, d_pred_taken0;
  logic [31:0] d_jump_target0, d_pc0, d_mispredict_addr0;

  typedef struct {
    string       n;
    logic [31:0] v;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard3_decode_predict #(.BRANCH_PREDICT(1'b1), .RAS_DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .d_instr(d_instr), .d_instr_is_32bit(d_instr_is_32bit),
    .d_instr_vld(d_instr_vld), .x_stall(x_stall), .f_jump_rdy(f_jump_rdy),
    .f_jump_now(f_jump_now), .f_jump_target(f_jump_target), .m_flush(m_flush),
    .d_stall(d_stall), .df_cir_lock(df_cir_lock), .d_jump_req(d_jump_req),
    .d_jump_target(d_jump_target), .d_pc(d_pc), .d_mispredict_addr(d_mispredict_addr),
    .d_pred_taken(d_pred_taken)
  );

  hazard3_decode_predict #(.BRANCH_PREDICT(1'b0), .RAS_DEPTH(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .d_instr(d_instr), .d_instr_is_32bit(d_instr_is_32bit),
    .d_instr_vld(d_instr_vld), .x_stall(x_stall), .f_jump_rdy(f_jump_rdy),
    .f_jump_now(f_jump_now), .f_jump_target(f_jump_target), .m_flush(m_flush),
    .d_stall(d_stall0), .df_cir_lock(df_cir_lock0), .d_jump_req(d_jump_req0),
    .d_jump_target(d_jump_target0), .d_pc(d_pc0), .d_mispredict_addr(d_mispredict_addr0),
    .d_pred_taken(d_pred_taken0)
  );

  function automatic logic [31:0] obs(input string n);
    case (n)
      "pc":    return d_pc;
      "req":   return {31'd0, d_jump_req};
      "tgt":   return d_jump_target;
      "mis":   return d_mispredict_addr;
      "pred":  return {31'd0, d_pred_taken};
      "lock":  return {31'd0, df_cir_lock};
      "stall": return {31'd0, d_stall};
      "empty": return {31'd0, u_dut.u_ras.empty};
      "top":   return u_dut.u_ras.top;
      "req0":  return {31'd0, d_jump_req0};
      "mis0":  return d_mispredict_addr0;
      "pred0": return {31'd0, d_pred_taken0};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [31:0] enc_jal(input logic [4:0] rd, input int imm);
    logic [20:0] i;
    i = imm[20:0];
    return {i[20], i[10:1], i[11], i[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1, input int imm);
    logic [11:0] i;
    i = imm[11:0];
    return {i, rs1, 3'b000, rd, 7'h67};
  endfunction

  function automatic logic [31:0] enc_beq(input int imm);
    logic [12:0] i;
    i = imm[12:0];
    return {i[12], i[10:5], 5'd0, 5'd0, 3'b000, i[4:1], i[11], 7'h63};
  endfunction

  task automatic ex(input string n, input logic [31:0] v);
    exp_t x;
    x.n = n;
    x.v = v;
    q.push_back(x);
  endtask

  task automatic drive(input logic [31:0] instr, input logic is32, input logic vld, input logic xs,
                       input logic rdy, input logic jn, input logic [31:0] tgt, input logic fl);
    d_instr = instr; d_instr_is_32bit = is32; d_instr_vld = vld; x_stall = xs;
    f_jump_rdy = rdy; f_jump_now = jn; f_jump_target = tgt; m_flush = fl;
  endtask

  task automatic apply_reset;
    drive(NOP, 1, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(NOP, 1, 0, 0, 0, 0, 0, 0);
    ex("pc", 32'h0); ex("req", 0); ex("lock", 0); ex("empty", 1); ex("stall", 1);
    #3;
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.n) !== e.v) begin errors++; $display("FAIL reset.%s got %h want %h", e.n, obs(e.n), e.v); end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_jal_jalr;
    apply_reset();
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: drive(NOP, 1, 0, 0, 1, 1, 32'h40, 0);
        1: begin
          drive(enc_jal(1, 32'h100), 1, 1, 0, 1, 1, 32'h140, 0);
          ex("pc", 32'h40); ex("req", 1); ex("tgt", 32'h140); ex("pred", 1);
          ex("mis", 32'h44); ex("stall", 0); ex("lock", 0);
        end
        2: begin
          drive(enc_jalr(0, 1, 0), 1, 1, 0, 1, 1, 32'h44, 0);
          ex("pc", 32'h140); ex("top", 32'h44); ex("empty", 0);
          ex("req", 1); ex("tgt", 32'h44); ex("pred", 1); ex("mis", 32'h144);
        end
        default: begin
          drive(NOP, 1, 0, 0, 1, 0, 0, 0);
          ex("pc", 32'h44); ex("empty", 1);
        end
      endcase
      #3;
      while (q.size() > 0) begin
        e = q.pop_front(); checks++;
        if (obs(e.n) !== e.v) begin errors++; $display("FAIL jal_jalr.%s step %0d got %h want %h", e.n, s, obs(e.n), e.v); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch;
    apply_reset();
    for (int s = 0; s < 6; s++) begin
      case (s)
        0: drive(NOP, 1, 0, 0, 1, 1, 32'h80, 0);
        1: begin
          drive(enc_beq(-8), 1, 1, 0, 1, 0, 0, 0);
          ex("req", 1); ex("tgt", 32'h78); ex("mis", 32'h84); ex("pred", 1);
          ex("req0", 0); ex("mis0", 32'h78); ex("pred0", 0);
        end
        2: begin
          drive(enc_beq(16), 1, 1, 0, 1, 0, 0, 0);
          ex("pc", 32'h84); ex("req", 0); ex("pred", 0); ex("mis", 32'h94);
          ex("req0", 0); ex("mis0", 32'h94);
        end
        3: drive(NOP, 1, 0, 0, 1, 1, 32'hFFFF_FFFE, 0);
        4: begin
          drive(NOP, 0, 1, 0, 1, 0, 0, 0);
          ex("pc", 32'hFFFF_FFFE); ex("mis", 32'h0); ex("req", 0); ex("pred", 0);
        end
        default: begin
          drive(NOP, 1, 0, 0, 1, 0, 0, 0);
          ex("pc", 32'h0);
        end
      endcase
      #3;
      while (q.size() > 0) begin
        e = q.pop_front(); checks++;
        if (obs(e.n) !== e.v) begin errors++; $display("FAIL branch.%s step %0d got %h want %h", e.n, s, obs(e.n), e.v); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall_lock;
    logic [31:0] jal;
    jal = enc_jal(1, 32'h20);
    apply_reset();
    for (int s = 0; s < 6; s++) begin
      case (s)
        0: drive(NOP, 1, 0, 0, 1, 1, 32'h200, 0);
        1: begin
          drive(jal, 1, 1, 1, 1, 1, 32'h220, 0);
          ex("req", 1); ex("stall", 1); ex("lock", 1); ex("pc", 32'h200); ex("mis", 32'h204);
        end
        2: begin
          drive(jal, 1, 1, 1, 1, 0, 32'h220, 0);
          ex("req", 0); ex("lock", 1); ex("pc", 32'h200); ex("pred", 1);
          ex("top", 32'h204); ex("empty", 0);
        end
        3: begin
          drive(jal, 1, 1, 0, 1, 0, 32'h220, 0);
          ex("lock", 0); ex("stall", 0); ex("req", 0);
        end
        4: begin
          drive(enc_jalr(0, 1, 0), 1, 1, 0, 1, 1, 32'h204, 0);
          ex("pc", 32'h220); ex("top", 32'h204); ex("req", 1); ex("tgt", 32'h204);
        end
        default: begin
          drive(NOP, 1, 0, 0, 1, 0, 0, 0);
          ex("empty", 1); ex("pc", 32'h204);
        end
      endcase
      #3;
      while (q.size() > 0) begin
        e = q.pop_front(); checks++;
        if (obs(e.n) !== e.v) begin errors++; $display("FAIL stall_lock.%s step %0d got %h want %h", e.n, s, obs(e.n), e.v); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ras_depth;
    apply_reset();
    for (int s = 0; s < 11; s++) begin
      case (s)
        0: drive(NOP, 1, 0, 0, 1, 1, 32'h10, 0);
        1: begin drive(enc_jal(1, 32'h10), 1, 1, 0, 1, 1, 32'h20, 0); ex("req", 1); ex("tgt", 32'h20); end
        2: begin drive(enc_jal(1, 32'h10), 1, 1, 0, 1, 1, 32'h30, 0); ex("tgt", 32'h30); end
        3: begin drive(enc_jal(5, 32'hD0), 1, 1, 0, 1, 1, 32'h100, 0); ex("tgt", 32'h100); end
        4: begin
          drive(enc_jalr(0, 1, 0), 1, 1, 0, 1, 1, 32'h34, 0);
          ex("pc", 32'h100); ex("req", 1); ex("tgt", 32'h34);
        end
        5: begin drive(enc_jalr(0, 5, 0), 1, 1, 0, 1, 1, 32'h24, 0); ex("req", 1); ex("tgt", 32'h24); end
        6: begin
          drive(enc_jalr(0, 1, 0), 1, 1, 0, 1, 0, 0, 0);
          ex("pc", 32'h24); ex("req", 0); ex("pred", 0); ex("empty", 1);
        end
        7: begin drive(enc_jal(1, 32'h10), 1, 1, 0, 1, 1, 32'h38, 0); ex("pc", 32'h28); ex("empty", 1); end
        8: begin
          drive(enc_jalr(1, 5, 0), 1, 1, 0, 1, 1, 32'h2C, 0);
          ex("top", 32'h2C); ex("req", 1); ex("tgt", 32'h2C);
        end
        9: begin
          drive(enc_jalr(1, 1, 0), 1, 1, 0, 1, 0, 0, 0);
          ex("pc", 32'h2C); ex("top", 32'h3C); ex("empty", 0); ex("req", 0); ex("pred", 0);
        end
        default: begin drive(NOP, 1, 0, 0, 1, 0, 0, 0); ex("top", 32'h30); end
      endcase
      #3;
      while (q.size() > 0) begin
        e = q.pop_front(); checks++;
        if (obs(e.n) !== e.v) begin errors++; $display("FAIL ras_depth.%s step %0d got %h want %h", e.n, s, obs(e.n), e.v); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush;
    logic [31:0] jal;
    jal = enc_jal(1, 32'h40);
    apply_reset();
    for (int s = 0; s < 6; s++) begin
      case (s)
        0: drive(NOP, 1, 0, 0, 1, 1, 32'h300, 0);
        1: begin drive(jal, 1, 1, 1, 1, 1, 32'h340, 0); ex("lock", 1); ex("req", 1); end
        2: begin drive(jal, 1, 1, 1, 1, 0, 32'h340, 1); ex("req", 0); ex("empty", 0); end
        3: begin
          drive(jal, 1, 0, 1, 1, 0, 32'h340, 0);
          ex("lock", 0); ex("empty", 1); ex("req", 0); ex("pc", 32'h300);
        end
        4: begin drive(jal, 1, 1, 0, 1, 0, 0, 1); ex("req", 0); ex("stall", 0); end
        default: begin drive(NOP, 1, 0, 0, 1, 0, 0, 0); ex("empty", 1); ex("pc", 32'h304); end
      endcase
      #3;
      while (q.size() > 0) begin
        e = q.pop_front(); checks++;
        if (obs(e.n) !== e.v) begin errors++; $display("FAIL flush.%s step %0d got %h want %h", e.n, s, obs(e.n), e.v); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid;
    apply_reset();
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: drive(NOP, 1, 0, 0, 1, 1, 32'h500, 0);
        1: begin drive(enc_jal(1, 8), 1, 1, 1, 1, 1, 32'h508, 0); ex("lock", 1); end
        default: begin
          drive(NOP, 1, 0, 1, 1, 0, 0, 0);
          rst_n = 1'b0;
          ex("pc", 32'h0); ex("lock", 0); ex("empty", 1); ex("req", 0);
        end
      endcase
      #3;
      while (q.size() > 0) begin
        e = q.pop_front(); checks++;
        if (obs(e.n) !== e.v) begin errors++; $display("FAIL reset_mid.%s step %0d got %h want %h", e.n, s, obs(e.n), e.v); end
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_jal_jalr();
    test_branch();
    test_stall_lock();
    test_ras_depth();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

endmodule
